// File: rtl/integral_window_ctrl_if.sv
// rtl/integral_window_ctrl_if.sv - window-memory read and integral-buffer write bus
interface integral_window_ctrl_if;
   // window-memory read port
   logic        pix_rd;
   logic [8:0]  pix_addr;
   logic [31:0] pix_data;
   // integral-buffer write port, shared with host Avalon writes
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [31:0] wr_data;
   logic        avl_wr_busy;

   // master: the sequencer; slave: memory / buffer side
   modport master (
      output pix_rd, pix_addr, wr_en, wr_addr, wr_data,
      input  pix_data, avl_wr_busy
   );
   modport slave (
      input  pix_rd, pix_addr, wr_en, wr_addr, wr_data,
      output pix_data, avl_wr_busy
   );
endinterface

// File: rtl/integral_window_ctrl.sv
// rtl/integral_window_ctrl.sv - builds the WINxWIN integral image into the integral buffer
module integral_window_ctrl #(
   parameter int WIN   = 20,
   parameter int PIX_W = 8,
   parameter int BASE  = 0
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   integral_window_ctrl_if.master        bus
);

   localparam int              NPIX     = WIN * WIN;
   localparam int              XW       = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [8:0]      LAST_IDX = 9'(NPIX - 1);
   localparam logic [XW-1:0]   LAST_X   = XW'(WIN - 1);
   localparam logic [8:0]      BASE_A   = 9'(BASE);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CALC,
      WRITE,
      DONE
   } state_t;

   state_t        state;
   state_t        state_n;

   logic          start_q;
   logic [8:0]    idx;
   logic [XW-1:0] x;
   logic [XW-1:0] y;
   logic [31:0]   rowsum;
   logic [31:0]   ii;
   logic [31:0]   line_buf [WIN];

   logic [31:0]   pix_val;
   logic [31:0]   rowsum_n;
   logic [31:0]   ii_n;
   logic          last_pix;
   logic          wr_go;

   // Only the low PIX_W bits of the read data carry the pixel.
   logic          unused_pix_hi;
   assign unused_pix_hi = ^bus.pix_data[31:PIX_W];

   assign pix_val  = {{(32-PIX_W){1'b0}}, bus.pix_data[PIX_W-1:0]};
   // Start of each row restarts the running row sum; row 0 has no row above.
   assign rowsum_n = ((x == '0) ? 32'd0 : rowsum) + pix_val;
   assign ii_n     = rowsum_n + ((y == '0) ? 32'd0 : line_buf[x]);
   assign last_pix = (idx == LAST_IDX);
   // Host writes own the buffer port; our write waits while one is in flight.
   assign wr_go    = (state == WRITE) && !bus.avl_wr_busy;

   // state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // next-state decode and output strobes
   always_comb begin
      state_n      = state;
      bus.pix_rd   = 1'b0;
      bus.pix_addr = 9'd0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = 9'd0;
      bus.wr_data  = 32'd0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (start && !start_q) begin
               state_n = READ;
            end
         end
         READ: begin
            bus.pix_rd   = 1'b1;
            bus.pix_addr = idx;
            busy         = 1'b1;
            state_n      = CALC;
         end
         CALC: begin
            busy    = 1'b1;
            state_n = WRITE;
         end
         WRITE: begin
            busy = 1'b1;
            if (wr_go) begin
               bus.wr_en   = 1'b1;
               bus.wr_addr = BASE_A + idx;
               bus.wr_data = ii;
               state_n     = last_pix ? DONE : READ;
            end
         end
         DONE: begin
            done = 1'b1;
            if (!start) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // pixel walk counters, row sum and integral output register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         // start_q comes out of reset high so a start level already present
         // at reset release is not taken as a rising edge.
         start_q <= 1'b1;
         idx     <= 9'd0;
         x       <= '0;
         y       <= '0;
         rowsum  <= 32'd0;
         ii      <= 32'd0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (start && !start_q) begin
                  idx <= 9'd0;
                  x   <= '0;
                  y   <= '0;
               end
            end
            CALC: begin
               rowsum <= rowsum_n;
               ii     <= ii_n;
            end
            WRITE: begin
               if (wr_go && !last_pix) begin
                  idx <= idx + 9'd1;
                  if (x == LAST_X) begin
                     x <= '0;
                     y <= y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // previous-row integral values; row 0 never reads them, so no reset needed
   always_ff @(posedge CLK) begin
      if (state == CALC) begin
         line_buf[x] <= ii_n;
      end
   end

endmodule

// File: tb/tb_integral_window_ctrl.sv
// tb/tb_integral_window_ctrl.sv - randomized self-checking bench for integral_window_ctrl
module tb_integral_window_ctrl;

   localparam int WIN  = 20;
   localparam int NPIX = WIN * WIN;
   localparam int BASE = 0;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   logic start = 1'b0;
   logic busy;
   logic done;

   integral_window_ctrl_if bus ();

   integral_window_ctrl #(
      .WIN   (WIN),
      .PIX_W (8),
      .BASE  (BASE)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem    [NPIX];
   logic [63:0] golden [NPIX];
   logic [31:0] wbuf   [512];
   logic [31:0] prev   [512];
   logic        pend   = 1'b0;
   logic [8:0]  paddr  = 9'd0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // integral image straight from its definition: sum of every pixel up-left
   task automatic compute_golden();
      int ky;
      int kx;
      logic [63:0] s;
      for (int k = 0; k < NPIX; k++) begin
         ky = k / WIN;
         kx = k % WIN;
         s  = 0;
         for (int j = 0; j <= ky; j++)
            for (int i = 0; i <= kx; i++)
               s += {56'd0, mem[j*WIN+i][7:0]};
         golden[k] = s;
      end
   endtask

   // advance one cycle; memory answers exactly one cycle after a read, junk otherwise
   task automatic tick();
      @(posedge CLK);
      #1;
      bus.pix_data = pend ? mem[paddr] : $urandom;
      pend = 1'b0;
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < NPIX; i++)
         case (mode)
            0:       mem[i] = 32'd1;
            1:       mem[i] = 32'd255;
            2:       mem[i] = 32'h1FF;
            default: mem[i] = $urandom;
         endcase
   endtask

   task automatic run_image(input string name, input int busy_pct, input int burst_at,
                            input int drop_at, input int hold_cycles, input int abort_at);
      int t, k, rd_cyc, stalls, burst_left, done_for, n_rd, n_wr;
      bit exp_rd, in_write, exp_wr, done_alive, post, ended, seen_done;
      compute_golden();
      for (int i = 0; i < 512; i++) wbuf[i] = 'x;
      k = 0; rd_cyc = 0; stalls = 0; burst_left = 5; done_for = 0; n_rd = 0; n_wr = 0;
      done_alive = 0; post = 0; ended = 0; seen_done = 0;
      start = 1'b1;
      for (t = 0; t < 8000; t++) begin
         tick();
         if (abort_at >= 0 && t == abort_at + 1) begin
            #1;
            check({name, "_rst_pix_rd"},   bus.pix_rd,   0);
            check({name, "_rst_pix_addr"}, bus.pix_addr, 0);
            check({name, "_rst_wr_en"},    bus.wr_en,    0);
            check({name, "_rst_wr_addr"},  bus.wr_addr,  0);
            check({name, "_rst_wr_data"},  bus.wr_data,  0);
            check({name, "_rst_busy"},     busy,         0);
            check({name, "_rst_done"},     done,         0);
            ended = 1;
            break;
         end
         if (drop_at >= 0 && t == drop_at) start = 1'b0;
         if (abort_at >= 0 && t == abort_at) RESET = 1'b1;
         if (done_alive && done_for >= hold_cycles) start = 1'b0;
         exp_rd   = (k < NPIX) && (t == rd_cyc);
         in_write = (k < NPIX) && (t >= rd_cyc + 2);
         if (burst_at == k && in_write && burst_left > 0) begin
            bus.avl_wr_busy = 1'b1;
            burst_left--;
         end else begin
            bus.avl_wr_busy = ($urandom_range(99) < busy_pct);
         end
         exp_wr = in_write && !bus.avl_wr_busy;
         if (in_write && bus.avl_wr_busy) stalls++;
         #1;
         check({name, "_pix_rd"}, bus.pix_rd, exp_rd);
         check({name, "_wr_en"},  bus.wr_en,  exp_wr);
         check({name, "_busy"},   busy,       k < NPIX);
         check({name, "_done"},   done,       done_alive);
         if (bus.pix_rd) begin
            pend  = 1'b1;
            paddr = bus.pix_addr;
            n_rd++;
         end
         if (exp_rd) check({name, "_pix_addr"}, bus.pix_addr, k);
         if (bus.wr_en) begin
            n_wr++;
            wbuf[bus.wr_addr] = bus.wr_data;
         end
         if (exp_wr) begin
            check({name, "_wr_addr"}, bus.wr_addr, BASE + k);
            check({name, "_wr_data"}, bus.wr_data, golden[k]);
         end
         if (done && !seen_done) begin
            seen_done = 1;
            check({name, "_done_delay"}, t, 1200 + stalls);
         end
         if (done_alive) begin
            done_for++;
            if (!start) begin
               done_alive = 0;
               post       = 1;
            end
         end else if (post) begin
            ended = 1;
            break;
         end
         if (exp_wr) begin
            k++;
            rd_cyc = t + 1;
            if (k == NPIX) done_alive = 1;
         end
      end
      if (!ended) check({name, "_timeout"}, 0, 1);
      if (abort_at < 0) begin
         check({name, "_reads"},  n_rd, NPIX);
         check({name, "_writes"}, n_wr, NPIX);
      end
      bus.avl_wr_busy = 1'b0;
   endtask

   initial begin
      int diffs;
      bus.pix_data    = 32'd0;
      bus.avl_wr_busy = 1'b0;
      RESET = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      #1;
      check("reset_pix_rd",   bus.pix_rd,   0);
      check("reset_pix_addr", bus.pix_addr, 0);
      check("reset_wr_en",    bus.wr_en,    0);
      check("reset_wr_addr",  bus.wr_addr,  0);
      check("reset_wr_data",  bus.wr_data,  0);
      check("reset_busy",     busy,         0);
      check("reset_done",     done,         0);
      RESET = 1'b0;
      repeat (2) tick();

      fill(0);
      run_image("ones", 0, -1, -1, 3, -1);
      check("ones_w0",   wbuf[BASE+0],   1);
      check("ones_w21",  wbuf[BASE+21],  4);
      check("ones_w399", wbuf[BASE+399], 400);
      repeat (2) tick();

      fill(1);
      run_image("p255", 0, -1, -1, 0, -1);
      check("p255_w0",   wbuf[BASE+0],   255);
      check("p255_w19",  wbuf[BASE+19],  5100);
      check("p255_w399", wbuf[BASE+399], 102000);
      repeat (2) tick();

      fill(2);
      run_image("p1ff", 0, -1, -1, 0, -1);
      check("p1ff_w0",   wbuf[BASE+0],   255);
      check("p1ff_w19",  wbuf[BASE+19],  5100);
      check("p1ff_w399", wbuf[BASE+399], 102000);
      repeat (2) tick();

      fill(3);
      run_image("stall", 30, 37, -1, 0, -1);
      repeat (2) tick();

      fill(3);
      run_image("drop", 20, -1, 100, 0, -1);
      repeat (2) tick();

      fill(3);
      run_image("held", 10, -1, -1, 6, -1);
      for (int i = 0; i < 512; i++) prev[i] = wbuf[i];
      repeat (2) tick();
      run_image("rerun", 10, -1, -1, 2, -1);
      diffs = 0;
      for (int i = 0; i < NPIX; i++)
         if (wbuf[BASE+i] !== prev[BASE+i]) diffs++;
      check("rerun_identical", diffs, 0);
      repeat (2) tick();

      fill(3);
      run_image("abort", 10, -1, -1, 0, 500);
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         check("no_launch_busy", busy, 0);
      end
      start = 1'b0;
      repeat (2) tick();
      fill(3);
      run_image("after_abort", 30, -1, -1, 0, -1);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
